// File: rtl/multicycle_logic_unit.sv
// Sliced bitwise logic unit (AND/OR/XOR/NOR) for the multicycle ALU datapath.
// Processes SLICE bits of the captured operands per clock. Res/Zero update
// atomically on the final slice, and done pulses for one cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; Res/Zero hold the last completed result
// RUN   | one slice per clock from the captured operands into acc
module multicycle_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res,
    output logic             Zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // A width that does not divide evenly into slices cannot be built.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("multicycle_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] slice_res;
    logic [WIDTH-1:0] acc_next;

    // Current slice of the captured operands through the selected operation.
    always_comb begin
        a_sl = a_q[cnt*SLICE +: SLICE];
        b_sl = b_q[cnt*SLICE +: SLICE];
        case (op_q)
            2'b00:   slice_res = a_sl & b_sl;
            2'b01:   slice_res = a_sl | b_sl;
            2'b10:   slice_res = a_sl ^ b_sl;
            default: slice_res = ~(a_sl | b_sl);
        endcase
    end

    // Accumulator with the current slice merged in; on the last slice this
    // is the complete result that goes straight to Res.
    always_comb begin
        acc_next = acc;
        acc_next[cnt*SLICE +: SLICE] = slice_res;
    end

    // Control FSM, operand capture, slice accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 2'b00;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Res   <= '0;
            Zero  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Res   <= acc_next;
                        Zero  <= (acc_next == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_logic_unit.sv
// Bench for multicycle_logic_unit: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the unit.
module tb_multicycle_logic_unit;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] A = '0, B = '0;
    logic         busy, done, Zero;
    logic [W-1:0] Res;

    logic         start16 = 1'b0;
    logic [1:0]   op16 = 2'b00;
    logic [15:0]  a16 = '0, b16 = '0;
    logic         busy16, done16, zero16;
    logic [15:0]  res16;

    logic         start64 = 1'b0;
    logic [1:0]   op64 = 2'b00;
    logic [63:0]  a64 = '0, b64 = '0;
    logic         busy64, done64, zero64;
    logic [63:0]  res64;

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    multicycle_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .Res(Res), .Zero(Zero));

    multicycle_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .Res(res16), .Zero(zero16));

    multicycle_logic_unit #(.WIDTH(64), .SLICE(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .op(op64), .A(a64), .B(b64),
        .busy(busy64), .done(done64), .Res(res64), .Zero(zero64));

    function automatic logic [63:0] lop(input logic [1:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: an accepted request yields op(A,B) N clocks later.
    logic         m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1;
    logic [W-1:0] m_res = '0, m_pend = '0;
    int           m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b1;
            m_res = '0; m_pend = '0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_res  = m_pend;
                    m_zero = (m_pend == '0);
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_pend = W'(lop(op, 64'(A), 64'(B)));
                m_rem  = N;
                m_busy = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_res",  64'(Res),  64'(m_res));
            chk("cyc_zero", 64'(Zero), 64'(m_zero));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and return at the done cycle (or on timeout) with start low.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output int bc);
        int guard;
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0;
        bc = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) bc++;
            if (noise) begin
                A = $urandom; B = $urandom; op = 2'($urandom);
                start = 1'($urandom);
            end
            tick();
            guard++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        int bc;
        int nd;
        logic [W-1:0] prev;
        logic [63:0]  ra, rb;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res",  64'(Res),  64'd0);
        chk("rst_zero", 64'(Zero), 64'd1);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Basic OR, latency and single-cycle done.
        run_op(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, bc);
        chk("or_busy_cycles", 64'(bc), 64'd4);
        chk("or_res",  64'(Res),  64'hF0F0_0F0F);
        chk("or_zero", 64'(Zero), 64'd0);
        tick();
        chk("or_done_width", 64'(done), 64'd0);

        // Input churn and start pulses during RUN are ignored.
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 1'b1, bc);
        chk("noise_res", 64'(Res), 64'hD1A2_4E1F);
        nd = 0;
        repeat (6) begin tick(); if (done) nd++; end
        chk("noise_extra_done", 64'(nd), 64'd0);
        chk("noise_no_queue", 64'(busy), 64'd0);

        // All four operations plus a zero result.
        run_op(2'b00, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, bc);
        chk("and_res", 64'(Res), 64'hFF00_0000);
        run_op(2'b01, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, bc);
        chk("or2_res", 64'(Res), 64'hFFFF_FF00);
        run_op(2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, bc);
        chk("xor_res", 64'(Res), 64'h00FF_FF00);
        run_op(2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, bc);
        chk("nor_res", 64'(Res), 64'h0000_00FF);
        chk("nor_zero", 64'(Zero), 64'd0);
        run_op(2'b00, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, bc);
        chk("and0_res",  64'(Res),  64'd0);
        chk("and0_zero", 64'(Zero), 64'd1);

        // Back-to-back: new start issued in the done cycle.
        run_op(2'b01, 32'h8000_0001, 32'h0000_0000, 1'b0, bc);
        prev = Res;
        start = 1'b1; op = 2'b10; A = 32'h1234_5678; B = 32'h1234_5678;
        tick();
        start = 1'b0;
        chk("b2b_accept", 64'(busy), 64'd1);
        repeat (N - 1) begin
            chk("b2b_hold", 64'(Res), 64'(prev));
            tick();
        end
        tick();
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_res",  64'(Res),  64'd0);
        chk("b2b_zero", 64'(Zero), 64'd1);
        tick();

        // Asynchronous reset two cycles into RUN.
        start = 1'b1; op = 2'b01; A = 32'h0000_00F0; B = 32'h0F00_0000;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_res",  64'(Res),  64'd0);
        chk("arst_zero", 64'(Zero), 64'd1);
        tick();
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (6) begin tick(); if (done) nd++; end
        chk("arst_no_done", 64'(nd), 64'd0);
        run_op(2'b01, 32'h0000_00F0, 32'h0F00_0000, 1'b0, bc);
        chk("arst_after_res", 64'(Res), 64'h0F00_00F0);
        chk("arst_after_lat", 64'(bc), 64'd4);
        tick();

        // Random traffic, checked by the cycle comparator.
        repeat (800) begin
            start = ($urandom_range(0, 3) != 0);
            op = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       begin A = $urandom; B = ~A; end
                1:       begin A = $urandom & 32'hFF00_FF00; B = $urandom & 32'h00FF_00FF; end
                default: begin A = $urandom; B = $urandom; end
            endcase
            tick();
        end
        start = 1'b0;
        repeat (8) tick();

        // Single-slice instance: one-cycle latency.
        chk("w16_idle", 64'(busy16), 64'd0);
        start16 = 1'b1; op16 = 2'b01; a16 = 16'h00FF; b16 = 16'hFF00;
        tick();
        start16 = 1'b0;
        chk("w16_busy", 64'(busy16), 64'd1);
        tick();
        chk("w16_done", 64'(done16), 64'd1);
        chk("w16_res",  64'(res16),  64'hFFFF);
        chk("w16_zero", 64'(zero16), 64'd0);

        // Wide instance: eight slices.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        start64 = 1'b1; op64 = 2'b10; a64 = ra; b64 = rb;
        tick();
        start64 = 1'b0;
        bc = 0;
        nd = 0;
        while (!done64 && nd < 40) begin
            if (busy64) bc++;
            tick();
            nd++;
        end
        chk("w64_busy_cycles", 64'(bc), 64'd8);
        chk("w64_res", res64, ra ^ rb);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
